// File: rtl/wb_i2c_cmd_sequencer.sv
// Wishbone master that replays queued I2CMB operations (enable, bus select, start,
// stop, byte write/read) and returns one status/data response per command.
module wb_i2c_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [2:0]            rsp_op_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [3:0]            rsp_status_o,
  output logic                  busy_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  irq_i
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ST_W   = 4;
  localparam int unsigned CMD_W  = OP_W + DATA_WIDTH;
  localparam int unsigned RSP_W  = OP_W + DATA_WIDTH + ST_W;
  localparam int unsigned CPTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CCNT_W = CPTR_W + 1;
  localparam int unsigned RPTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned RCNT_W = RPTR_W + 1;
  localparam int unsigned TMO_W  = 16;

  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [OP_W-1:0] OP_ENABLE    = 3'd0;
  localparam logic [OP_W-1:0] OP_DISABLE   = 3'd1;
  localparam logic [OP_W-1:0] OP_SET_BUS   = 3'd2;
  localparam logic [OP_W-1:0] OP_START     = 3'd3;
  localparam logic [OP_W-1:0] OP_STOP      = 3'd4;
  localparam logic [OP_W-1:0] OP_WRITE     = 3'd5;
  localparam logic [OP_W-1:0] OP_READ_ACK  = 3'd6;
  localparam logic [OP_W-1:0] OP_READ_NACK = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] ADR_CSR  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADR_DPR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_CMDR = ADDR_WIDTH'(2);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_CSR, S_WR_DPR, S_WR_CMDR,
    S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR, S_PUSH
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]       op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ST_W-1:0]       status_q, status_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;

  logic                  xfer_req, xfer_we, xfer_done;
  logic [ADDR_WIDTH-1:0] xfer_adr;
  logic [DATA_WIDTH-1:0] xfer_dat;

  logic busy_q, busy_d;

  // Command FIFO
  logic [CMD_W-1:0]  cmd_mem_q [CMD_DEPTH];
  logic [CPTR_W-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CCNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_push, cmd_pop;
  logic [CMD_W-1:0]  cmd_head;

  // Response FIFO (first-word-fall-through, head word held in a register)
  logic [RSP_W-1:0]  rsp_mem_q [RSP_DEPTH];
  logic [RPTR_W-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RCNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]  rsp_head_q, rsp_head_d;
  logic              rsp_push, rsp_pop, rsp_full;
  logic [RSP_W-1:0]  rsp_word;

  assign cmd_push = cmd_valid_i && cmd_ready_q;
  assign cmd_head = cmd_mem_q[cmd_rd_q];
  assign rsp_pop  = rsp_valid_q && rsp_ready_i;
  assign rsp_full = (rsp_cnt_q == RCNT_W'(RSP_DEPTH));
  assign rsp_word = {op_q, rsp_data_q, status_q};

  always_comb begin
    cmd_wr_d    = cmd_wr_q + CPTR_W'(cmd_push);
    cmd_rd_d    = cmd_rd_q + CPTR_W'(cmd_pop);
    cmd_cnt_d   = cmd_cnt_q + CCNT_W'(cmd_push) - CCNT_W'(cmd_pop);
    cmd_ready_d = (cmd_cnt_d != CCNT_W'(CMD_DEPTH));
  end

  always_comb begin
    rsp_wr_d    = rsp_wr_q + RPTR_W'(rsp_push);
    rsp_rd_d    = rsp_rd_q + RPTR_W'(rsp_pop);
    rsp_cnt_d   = rsp_cnt_q + RCNT_W'(rsp_push) - RCNT_W'(rsp_pop);
    rsp_valid_d = (rsp_cnt_d != '0);
    // The only entry is the one being written this cycle, so it is not in memory yet.
    if (rsp_cnt_d == '0) begin
      rsp_head_d = '0;
    end else if (rsp_push && (rsp_cnt_d == RCNT_W'(1))) begin
      rsp_head_d = rsp_word;
    end else begin
      rsp_head_d = rsp_mem_q[rsp_rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {cmd_op_i, cmd_data_i};
    if (rsp_push) rsp_mem_q[rsp_wr_q] <= rsp_word;
  end

  // Register and data of the Wishbone access belonging to the current state
  always_comb begin
    xfer_req = 1'b1;
    xfer_we  = 1'b1;
    xfer_adr = ADR_CMDR;
    xfer_dat = '0;
    case (state_q)
      S_WR_CSR: begin
        xfer_adr = ADR_CSR;
        xfer_dat = (op_q == OP_ENABLE) ? DATA_WIDTH'(8'hC0) : '0;
      end
      S_WR_DPR: begin
        xfer_adr = ADR_DPR;
        xfer_dat = data_q;
      end
      S_WR_CMDR: begin
        case (op_q)
          OP_SET_BUS:   xfer_dat = DATA_WIDTH'(8'h06);
          OP_START:     xfer_dat = DATA_WIDTH'(8'h04);
          OP_STOP:      xfer_dat = DATA_WIDTH'(8'h05);
          OP_WRITE:     xfer_dat = DATA_WIDTH'(8'h01);
          OP_READ_ACK:  xfer_dat = DATA_WIDTH'(8'h02);
          OP_READ_NACK: xfer_dat = DATA_WIDTH'(8'h03);
          default:      xfer_dat = '0;
        endcase
      end
      S_RD_CMDR: xfer_we = 1'b0;
      S_RD_DPR: begin
        xfer_we  = 1'b0;
        xfer_adr = ADR_DPR;
      end
      default: xfer_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    status_d   = status_q;
    tmo_cnt_d  = tmo_cnt_q;
    wb_cyc_d   = wb_cyc_q;
    wb_we_d    = wb_we_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    xfer_done  = 1'b0;
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;

    // A new access only starts from an idle bus, which leaves one idle cycle between accesses.
    if (xfer_req) begin
      if (!wb_cyc_q) begin
        wb_cyc_d = 1'b1;
        wb_we_d  = xfer_we;
        wb_adr_d = xfer_adr;
        wb_dat_d = xfer_dat;
      end else if (wb_ack_i) begin
        wb_cyc_d  = 1'b0;
        wb_we_d   = 1'b0;
        wb_adr_d  = '0;
        wb_dat_d  = '0;
        xfer_done = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (cmd_cnt_q != '0) state_d = S_FETCH;
      S_FETCH: begin
        cmd_pop    = 1'b1;
        op_d       = cmd_head[CMD_W-1 -: OP_W];
        data_d     = cmd_head[DATA_WIDTH-1:0];
        status_d   = '0;
        rsp_data_d = '0;
        case (cmd_head[CMD_W-1 -: OP_W])
          OP_ENABLE, OP_DISABLE: state_d = S_WR_CSR;
          OP_SET_BUS, OP_WRITE:  state_d = S_WR_DPR;
          default:               state_d = S_WR_CMDR;
        endcase
      end
      S_WR_CSR: if (xfer_done) state_d = S_PUSH;
      S_WR_DPR: if (xfer_done) state_d = S_WR_CMDR;
      S_WR_CMDR: begin
        if (xfer_done) begin
          state_d   = S_WAIT_IRQ;
          tmo_cnt_d = '0;
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_RD_CMDR;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          state_d    = S_PUSH;
          status_d   = 4'b1000;
          rsp_data_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_RD_CMDR: begin
        if (xfer_done) begin
          status_d = {1'b0, wb_dat_i[4], wb_dat_i[5], wb_dat_i[6]};
          if (((op_q == OP_READ_ACK) || (op_q == OP_READ_NACK)) && (wb_dat_i[6:4] == 3'b000)) begin
            state_d = S_RD_DPR;
          end else begin
            state_d = S_PUSH;
          end
        end
      end
      S_RD_DPR: begin
        if (xfer_done) begin
          rsp_data_d = wb_dat_i;
          state_d    = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!rsp_full) begin
          rsp_push = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (cmd_cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      status_q    <= '0;
      tmo_cnt_q   <= '0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      busy_q      <= 1'b0;
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_head_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      status_q    <= status_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      busy_q      <= busy_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_cnt_q   <= cmd_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_head_q  <= rsp_head_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_op_o     = rsp_head_q[RSP_W-1 -: OP_W];
  assign rsp_data_o   = rsp_head_q[ST_W +: DATA_WIDTH];
  assign rsp_status_o = rsp_head_q[ST_W-1:0];
  assign busy_o       = busy_q;
  assign wb_cyc_o     = wb_cyc_q;
  assign wb_stb_o     = wb_cyc_q;
  assign wb_we_o      = wb_we_q;
  assign wb_adr_o     = wb_adr_q;
  assign wb_dat_o     = wb_dat_q;

endmodule

// File: tb/tb_wb_i2c_cmd_sequencer.sv
// Directed bench: a small I2CMB-like Wishbone slave with irq, logging every access.
module tb_wb_i2c_cmd_sequencer;

  localparam int LIM = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_op;
  logic [7:0] rsp_data;
  logic [3:0] rsp_status;
  logic       busy;
  logic       wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack;
  logic       irq;

  logic [7:0] cmdr_val, dpr_val;
  logic       irq_en;
  int         irq_delay;
  int         irq_cnt;

  logic [10:0] wb_log [0:255];
  int          n_log = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_i2c_cmd_sequencer #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op),
    .rsp_data_o(rsp_data), .rsp_status_o(rsp_status), .busy_o(busy),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .irq_i(irq)
  );

  assign wb_dat_i = (wb_adr == 2'd2) ? cmdr_val : (wb_adr == 2'd1) ? dpr_val : 8'h00;

  // Slave: one-cycle ack, irq some cycles after a CMDR write, cleared by a CMDR read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack  <= 1'b0;
      irq     <= 1'b0;
      irq_cnt <= 0;
    end else begin
      wb_ack <= wb_cyc && wb_stb && !wb_ack;
      if (wb_cyc && wb_stb && !wb_ack) begin
        if (wb_we && wb_adr == 2'd2 && irq_en) irq_cnt <= irq_delay;
        if (!wb_we && wb_adr == 2'd2) irq <= 1'b0;
      end else if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wb_cyc && wb_stb && !wb_ack && n_log < 256) begin
      wb_log[n_log] <= {wb_we, wb_adr, wb_dat_o};
      n_log <= n_log + 1;
    end
  end

  function automatic logic [10:0] wbw(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [10:0] wbr(input logic [1:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=no event expected=event within %0d cycles", tag, LIM);
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) wait_fail("cmd_ready_wait");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [2:0] op, output logic [7:0] d, output logic [3:0] st);
    int t;
    t = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) wait_fail("rsp_valid_wait");
    op = rsp_op; d = rsp_data; st = rsp_status;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [2:0]  r_op;
  logic [7:0]  r_d;
  logic [3:0]  r_st;
  logic [10:0] exp_log [0:9];
  int          base;
  int          t;
  int          k;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; rsp_ready = 1'b0;
    cmdr_val = 8'h80; dpr_val = 8'h00; irq_en = 1'b1; irq_delay = 10;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wb_cyc", wb_cyc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // ENABLE: single CSR write, no IRQ wait
    base = n_log;
    push_cmd(3'd0, 8'h00);
    get_rsp(r_op, r_d, r_st);
    chk("en_rsp_op", r_op, 0);
    chk("en_rsp_status", r_st, 0);
    chk("en_rsp_data", r_d, 0);
    repeat (3) @(negedge clk);
    chk("en_wb_count", n_log - base, 1);
    chk("en_wb0", wb_log[base], wbw(2'd0, 8'hC0));
    chk("en_busy_idle", busy, 0);

    // SET_BUS 5
    base = n_log;
    push_cmd(3'd2, 8'h05);
    get_rsp(r_op, r_d, r_st);
    chk("bus_rsp_op", r_op, 2);
    chk("bus_rsp_status", r_st, 0);
    chk("bus_rsp_data", r_d, 0);
    chk("bus_wb_count", n_log - base, 3);
    chk("bus_wb0", wb_log[base], wbw(2'd1, 8'h05));
    chk("bus_wb1", wb_log[base+1], wbw(2'd2, 8'h06));
    chk("bus_wb2", wb_log[base+2], wbr(2'd2));

    // START, WRITE 0x44, READ_NACK, STOP queued back to back
    dpr_val = 8'hA5;
    base = n_log;
    push_cmd(3'd3, 8'h00);
    push_cmd(3'd5, 8'h44);
    push_cmd(3'd7, 8'h00);
    push_cmd(3'd4, 8'h00);
    get_rsp(r_op, r_d, r_st);
    chk("seq_r0", {r_op, r_d, r_st}, {3'd3, 8'h00, 4'h0});
    get_rsp(r_op, r_d, r_st);
    chk("seq_r1", {r_op, r_d, r_st}, {3'd5, 8'h00, 4'h0});
    get_rsp(r_op, r_d, r_st);
    chk("seq_r2", {r_op, r_d, r_st}, {3'd7, 8'hA5, 4'h0});
    get_rsp(r_op, r_d, r_st);
    chk("seq_r3", {r_op, r_d, r_st}, {3'd4, 8'h00, 4'h0});
    exp_log[0] = wbw(2'd2, 8'h04); exp_log[1] = wbr(2'd2);
    exp_log[2] = wbw(2'd1, 8'h44); exp_log[3] = wbw(2'd2, 8'h01); exp_log[4] = wbr(2'd2);
    exp_log[5] = wbw(2'd2, 8'h03); exp_log[6] = wbr(2'd2);       exp_log[7] = wbr(2'd1);
    exp_log[8] = wbw(2'd2, 8'h05); exp_log[9] = wbr(2'd2);
    chk("seq_wb_count", n_log - base, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("seq_wb%0d", i), wb_log[base+i], exp_log[i]);

    // WRITE answered with NAK, then ENABLE still runs
    cmdr_val = 8'hC0;
    base = n_log;
    push_cmd(3'd5, 8'h12);
    push_cmd(3'd0, 8'h00);
    get_rsp(r_op, r_d, r_st);
    chk("nak_r0", {r_op, r_d, r_st}, {3'd5, 8'h00, 4'b0001});
    get_rsp(r_op, r_d, r_st);
    chk("nak_r1", {r_op, r_d, r_st}, {3'd0, 8'h00, 4'b0000});
    chk("nak_wb_count", n_log - base, 4);
    chk("nak_wb0", wb_log[base], wbw(2'd1, 8'h12));
    chk("nak_wb1", wb_log[base+1], wbw(2'd2, 8'h01));
    chk("nak_wb2", wb_log[base+2], wbr(2'd2));
    chk("nak_wb3", wb_log[base+3], wbw(2'd0, 8'hC0));
    cmdr_val = 8'h80;

    // Timeout: START with irq never raised
    irq_en = 1'b0;
    base = n_log;
    push_cmd(3'd3, 8'h00);
    t = 0;
    while (!(wb_cyc && wb_ack && wb_we && wb_adr == 2'd2) && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) wait_fail("tmo_cmdr_ack_wait");
    k = 0;
    do begin
      @(posedge clk); k++;
      @(negedge clk);
    end while (!rsp_valid && k < LIM);
    chk("tmo_latency_edges", k, 18);
    get_rsp(r_op, r_d, r_st);
    chk("tmo_rsp", {r_op, r_d, r_st}, {3'd3, 8'h00, 4'b1000});
    chk("tmo_wb_count", n_log - base, 1);
    irq_en = 1'b1;

    // Backpressure: 9 commands fill response FIFO, PUSH slot and command FIFO
    for (int i = 0; i < 9; i++) push_cmd((i % 2 == 1) ? 3'd1 : 3'd0, 8'h00);
    repeat (30) @(negedge clk);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 9; i++) begin
      get_rsp(r_op, r_d, r_st);
      chk($sformatf("bp_r%0d", i), {r_op, r_d, r_st}, {((i % 2 == 1) ? 3'd1 : 3'd0), 8'h00, 4'h0});
    end
    repeat (5) @(negedge clk);
    chk("bp_drained_valid", rsp_valid, 0);
    chk("bp_drained_busy", busy, 0);

    // Reset in the middle of the SET_BUS DPR write
    push_cmd(3'd0, 8'h00);
    push_cmd(3'd0, 8'h00);
    push_cmd(3'd2, 8'h03);
    push_cmd(3'd3, 8'h00);
    t = 0;
    while (!(wb_cyc && wb_adr == 2'd1) && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) wait_fail("mid_dpr_wait");
    chk("mid_pre_rsp_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wb_cyc", wb_cyc, 0);
    chk("mid_wb_stb", wb_stb, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_wb_cyc", wb_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
